bus_arbiter: RTL and testbench

- Shares one external memory bus between the IF stage (instruction fetch) and the MEM stage (loads/stores) of the 5-stage core.
- Provides a fixed-priority FSM with an anti-starvation counter, a per-transaction timeout watchdog and a pipeline stall request.
- Sits between the core's fetch/data ports and the SRAM-like bus.
- The requester-to-bus path is fully registered.

---
 rtl/bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Arbitrates one SRAM-like bus between the fetch (IF) and data (MEM) ports,
// with burst-limited MEM priority, a per-transaction watchdog and a stall request.
module bus_arbiter #(
    parameter int unsigned DW            = 32,
    parameter int unsigned AW            = 32,
    parameter int unsigned MEM_BURST_MAX = 4,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_ack_o,
    output logic          if_err_o,

    input  logic          mem_req_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_wdata_i,
    input  logic [3:0]    mem_sel_i,
    output logic [DW-1:0] mem_rdata_o,
    output logic          mem_ack_o,
    output logic          mem_err_o,

    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    output logic [3:0]    bus_sel_o,
    input  logic [DW-1:0] bus_rdata_i,
    input  logic          bus_ack_i,

    output logic          stallreq_o
);

    localparam logic [3:0] BURST_MAX = 4'(MEM_BURST_MAX);
    localparam logic [7:0] TMO_LAST  = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam bit         TMO_EN    = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY_IF,
        S_BUSY_MEM,
        S_RESP_IF,
        S_RESP_MEM
    } state_t;

    state_t        state_q;
    logic [3:0]    burst_cnt_q;
    logic [7:0]    tmo_cnt_q;
    logic          bus_req_q;
    logic          bus_we_q;
    logic [AW-1:0] bus_addr_q;
    logic [DW-1:0] bus_wdata_q;
    logic [3:0]    bus_sel_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] mem_rdata_q;
    logic          if_ack_q;
    logic          if_err_q;
    logic          mem_ack_q;
    logic          mem_err_q;
    logic          stall_q;

    logic grant_if;
    logic grant_mem;
    logic busy;
    logic done_ok;
    logic done_tmo;
    logic if_ack_d;
    logic mem_ack_d;
    logic stall_d;

    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state_q == S_IDLE) begin
            if (mem_req_i && (!if_req_i || burst_cnt_q != BURST_MAX))
                grant_mem = 1'b1;
            else if (if_req_i)
                grant_if = 1'b1;
        end
        busy      = (state_q == S_BUSY_IF) || (state_q == S_BUSY_MEM);
        done_ok   = busy && bus_ack_i;
        // An ack landing on the last allowed cycle wins over the abort.
        done_tmo  = busy && !bus_ack_i && TMO_EN && (tmo_cnt_q == TMO_LAST);
        if_ack_d  = (state_q == S_BUSY_IF)  && (done_ok || done_tmo);
        mem_ack_d = (state_q == S_BUSY_MEM) && (done_ok || done_tmo);
        // A requester still holding req in its ack cycle is retiring, not waiting.
        stall_d   = (if_req_i  && !if_ack_d  && (state_q != S_RESP_IF)) ||
                    (mem_req_i && !mem_ack_d && (state_q != S_RESP_MEM));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            burst_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            mem_err_q   <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            if_ack_q  <= if_ack_d;
            if_err_q  <= if_ack_d && done_tmo;
            mem_ack_q <= mem_ack_d;
            mem_err_q <= mem_ack_d && done_tmo;
            stall_q   <= stall_d;

            case (state_q)
                S_IDLE: begin
                    if (grant_mem) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_we_i;
                        bus_addr_q  <= mem_addr_i;
                        bus_wdata_q <= mem_wdata_i;
                        bus_sel_q   <= mem_sel_i;
                        tmo_cnt_q   <= '0;
                        state_q     <= S_BUSY_MEM;
                        if (!if_req_i)
                            burst_cnt_q <= '0;
                        else if (burst_cnt_q != BURST_MAX)
                            burst_cnt_q <= burst_cnt_q + 4'd1;
                    end else if (grant_if) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= if_addr_i;
                        bus_wdata_q <= '0;
                        bus_sel_q   <= 4'hF;
                        tmo_cnt_q   <= '0;
                        burst_cnt_q <= '0;
                        state_q     <= S_BUSY_IF;
                    end
                end

                S_BUSY_IF, S_BUSY_MEM: begin
                    if (done_ok) begin
                        bus_req_q <= 1'b0;
                        if (state_q == S_BUSY_IF) begin
                            if_rdata_q <= bus_rdata_i;
                            state_q    <= S_RESP_IF;
                        end else begin
                            if (!bus_we_q)
                                mem_rdata_q <= bus_rdata_i;
                            state_q <= S_RESP_MEM;
                        end
                    end else if (done_tmo) begin
                        bus_req_q <= 1'b0;
                        if (state_q == S_BUSY_IF) begin
                            if_rdata_q <= '0;
                            state_q    <= S_RESP_IF;
                        end else begin
                            mem_rdata_q <= '0;
                            state_q     <= S_RESP_MEM;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end

                S_RESP_IF, S_RESP_MEM: state_q <= S_IDLE;

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign if_err_o    = if_err_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_ack_o   = mem_ack_q;
    assign mem_err_o   = mem_err_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_sel_o   = bus_sel_q;
    assign stallreq_o  = stall_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, cycle-exact bench for bus_arbiter with MEM_BURST_MAX=4, TIMEOUT=8.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        if_err_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        mem_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        stallreq_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .DW(32),
        .AW(32),
        .MEM_BURST_MAX(4),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req_i(if_req_i),
        .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o),
        .if_ack_o(if_ack_o),
        .if_err_o(if_err_o),
        .mem_req_i(mem_req_i),
        .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_sel_i(mem_sel_i),
        .mem_rdata_o(mem_rdata_o),
        .mem_ack_o(mem_ack_o),
        .mem_err_o(mem_err_o),
        .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_sel_o(bus_sel_o),
        .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i),
        .stallreq_o(stallreq_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] grant_log [$];
        logic [31:0] exp_seq   [6];
        int          n_mem_ack;
        int          n_if_ack;

        rst = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_sel_i = '0;
        bus_rdata_i = '0; bus_ack_i = 1'b0;
        tick(); tick();
        check("reset_bus_req", bus_req_o, 0);
        check("reset_if_ack", if_ack_o, 0);
        check("reset_mem_ack", mem_ack_o, 0);
        check("reset_stall", stallreq_o, 0);
        check("reset_bus_addr", bus_addr_o, 0);
        check("reset_bus_sel", bus_sel_o, 0);
        rst = 1'b1;
        tick();

        // Single fetch
        if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
        tick();
        check("f1_bus_req", bus_req_o, 1);
        check("f1_bus_addr", bus_addr_o, 32'h40);
        check("f1_bus_we", bus_we_o, 0);
        check("f1_bus_sel", bus_sel_o, 4'hF);
        check("f1_stall_busy", stallreq_o, 1);
        check("f1_no_early_ack", if_ack_o, 0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h3401_1100;
        tick();
        check("f1_if_ack", if_ack_o, 1);
        check("f1_if_err", if_err_o, 0);
        check("f1_if_rdata", if_rdata_o, 32'h3401_1100);
        check("f1_bus_req_drop", bus_req_o, 0);
        check("f1_stall_ackcycle", stallreq_o, 0);
        bus_ack_i = 1'b0;
        tick();
        check("f1_ack_one_cycle", if_ack_o, 0);
        check("f1_no_regrant", bus_req_o, 0);
        if_req_i = 1'b0;
        tick();
        check("f1_idle", bus_req_o, 0);
        tick();

        // Simultaneous requests: MEM store first, then IF
        if_req_i = 1'b1; if_addr_i = 32'h80;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h100;
        mem_wdata_i = 32'hDEAD_BEEF; mem_sel_i = 4'b0011;
        tick();
        check("sim_bus_addr_mem", bus_addr_o, 32'h100);
        check("sim_bus_we", bus_we_o, 1);
        check("sim_bus_wdata", bus_wdata_o, 32'hDEAD_BEEF);
        check("sim_bus_sel", bus_sel_o, 4'b0011);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
        tick();
        check("sim_mem_ack", mem_ack_o, 1);
        check("sim_mem_err", mem_err_o, 0);
        check("sim_if_ack_not_yet", if_ack_o, 0);
        check("sim_write_keeps_rdata", mem_rdata_o, 0);
        check("sim_stall_if_waiting", stallreq_o, 1);
        bus_ack_i = 1'b0;
        tick();
        check("sim_no_dup_grant", bus_req_o, 0);
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        tick();
        check("sim_if_grant", bus_req_o, 1);
        check("sim_if_addr", bus_addr_o, 32'h80);
        check("sim_if_we", bus_we_o, 0);
        check("sim_if_sel", bus_sel_o, 4'hF);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
        tick();
        check("sim_if_ack", if_ack_o, 1);
        check("sim_if_rdata", if_rdata_o, 32'h1111_2222);
        bus_ack_i = 1'b0;
        tick();
        if_req_i = 1'b0;
        tick(); tick();

        // Starvation guard: both held, bus always acking
        exp_seq[0] = 32'h200; exp_seq[1] = 32'h200; exp_seq[2] = 32'h200;
        exp_seq[3] = 32'h200; exp_seq[4] = 32'h300; exp_seq[5] = 32'h200;
        n_mem_ack = 0; n_if_ack = 0;
        if_req_i = 1'b1; if_addr_i = 32'h300;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h200; mem_sel_i = 4'hF;
        bus_ack_i = 1'b1; bus_rdata_i = 32'hA5A5_A5A5;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (bus_req_o) grant_log.push_back(bus_addr_o);
            if (mem_ack_o) n_mem_ack++;
            if (if_ack_o) n_if_ack++;
        end
        if_req_i = 1'b0; mem_req_i = 1'b0; bus_ack_i = 1'b0;
        check("starve_grant_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size())
                check($sformatf("starve_grant%0d", i), grant_log[i], exp_seq[i]);
        check("starve_mem_acks", n_mem_ack, 5);
        check("starve_if_acks", n_if_ack, 1);
        check("starve_mem_rdata", mem_rdata_o, 32'hA5A5_A5A5);
        tick(); tick();

        // Timeout: MEM read, bus never acks
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h400;
        tick();
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("tmo_bus_req_c%0d", i), bus_req_o, 1);
            tick();
        end
        check("tmo_bus_req_drop", bus_req_o, 0);
        check("tmo_mem_ack", mem_ack_o, 1);
        check("tmo_mem_err", mem_err_o, 1);
        check("tmo_mem_rdata", mem_rdata_o, 0);
        tick();
        check("tmo_idle_no_regrant", bus_req_o, 0);
        check("tmo_ack_one_cycle", mem_ack_o, 0);
        mem_req_i = 1'b0;
        tick(); tick();

        // Ack on the timeout cycle counts as success
        mem_req_i = 1'b1; mem_addr_i = 32'h500;
        tick();
        for (int i = 1; i < 8; i++) tick();
        check("edge_bus_req_c8", bus_req_o, 1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
        tick();
        check("edge_mem_ack", mem_ack_o, 1);
        check("edge_mem_err", mem_err_o, 0);
        check("edge_mem_rdata", mem_rdata_o, 32'hCAFE_F00D);
        bus_ack_i = 1'b0;
        tick();
        mem_req_i = 1'b0;
        tick(); tick();

        // Reset in the middle of a MEM transaction
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h600;
        mem_wdata_i = 32'h1234_5678; mem_sel_i = 4'hC;
        tick();
        check("rst_busy_before", bus_req_o, 1);
        tick();
        rst = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        tick();
        check("rst_bus_req", bus_req_o, 0);
        check("rst_bus_addr", bus_addr_o, 0);
        check("rst_bus_wdata", bus_wdata_o, 0);
        check("rst_mem_ack", mem_ack_o, 0);
        check("rst_mem_rdata", mem_rdata_o, 0);
        check("rst_if_rdata", if_rdata_o, 0);
        check("rst_stall", stallreq_o, 0);
        rst = 1'b1;
        tick();
        check("rst_no_late_ack", mem_ack_o, 0);
        if_req_i = 1'b1; if_addr_i = 32'h700;
        tick();
        check("post_rst_bus_req", bus_req_o, 1);
        check("post_rst_bus_addr", bus_addr_o, 32'h700);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_C0DE;
        tick();
        check("post_rst_if_ack", if_ack_o, 1);
        check("post_rst_if_err", if_err_o, 0);
        check("post_rst_if_rdata", if_rdata_o, 32'h0BAD_C0DE);
        bus_ack_i = 1'b0;
        tick();
        if_req_i = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
